// File: rtl/lane_pkg.sv
// rtl/lane_pkg.sv - shared lane types and constants for the VRF write path
package lane_pkg;

   localparam int VRF_OFFSET_WIDTH = 8;
   localparam int VRF_DATA_WIDTH   = 32;
   localparam int VRF_VD_WIDTH     = 5;
   localparam int VRF_INDEX_WIDTH  = 3;

   typedef struct packed {
      logic [VRF_VD_WIDTH-1:0]     vd;
      logic [VRF_OFFSET_WIDTH-1:0] offset;
      logic [VRF_DATA_WIDTH/8-1:0] mask;
      logic [VRF_DATA_WIDTH-1:0]   data;
      logic                        last;
      logic [VRF_INDEX_WIDTH-1:0]  instructionIndex;
   } vrf_write_req_t;

endpackage

// File: rtl/lane_merge_queue.sv
// rtl/lane_merge_queue.sv - circular buffer whose tail entry can absorb a matching write
module lane_merge_queue
   import lane_pkg::*;
#(
   parameter int KEY_WIDTH  = 16,
   parameter int TAG_WIDTH  = 3,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4,
   parameter int MERGE_EN   = 1,
   localparam int MASK_WIDTH = DATA_WIDTH / 8,
   localparam int PTR_WIDTH  = $clog2(DEPTH)
) (
   input  logic                       clock,
   input  logic                       reset,
   output logic                       inReady,
   input  logic                       inValid,
   input  logic [KEY_WIDTH-1:0]       inKey,
   input  logic [DATA_WIDTH-1:0]      inData,
   input  logic [MASK_WIDTH-1:0]      inMask,
   input  logic                       inLast,
   input  logic                       outReady,
   output logic                       outValid,
   output logic [KEY_WIDTH-1:0]       outKey,
   output logic [DATA_WIDTH-1:0]      outData,
   output logic [MASK_WIDTH-1:0]      outMask,
   output logic                       outLast,
   output logic [PTR_WIDTH:0]         count,
   output logic [DEPTH-1:0]           slotValidNext,
   output logic [DEPTH*TAG_WIDTH-1:0] slotTagNext
);

   localparam int CNT_WIDTH = PTR_WIDTH + 1;

   logic [KEY_WIDTH-1:0]  keyMem  [DEPTH];
   logic [DATA_WIDTH-1:0] dataMem [DEPTH];
   logic [MASK_WIDTH-1:0] maskMem [DEPTH];
   logic [DEPTH-1:0]      lastMem;

   logic [PTR_WIDTH-1:0] rdPtr, wrPtr, tailPtr, rdNext, wrNext, rel;
   logic [CNT_WIDTH-1:0] countNext;
   logic                 push, pop, mergeHit, pushNew;

   assign inReady  = (count != CNT_WIDTH'(DEPTH));
   assign outValid = (count != '0);
   assign push     = inValid & inReady;
   assign pop      = outValid & outReady;
   assign tailPtr  = wrPtr - PTR_WIDTH'(1);

   // A single-entry queue being drained this cycle cannot absorb the new write.
   assign mergeHit = (MERGE_EN != 0) && push && (count != '0) &&
                     (keyMem[tailPtr] == inKey) && !(pop && count == CNT_WIDTH'(1));
   assign pushNew  = push && !mergeHit;

   assign rdNext    = pop ? rdPtr + PTR_WIDTH'(1) : rdPtr;
   assign wrNext    = pushNew ? wrPtr + PTR_WIDTH'(1) : wrPtr;
   assign countNext = count + CNT_WIDTH'(pushNew) - CNT_WIDTH'(pop);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rdPtr <= '0;
         wrPtr <= '0;
         count <= '0;
      end else begin
         rdPtr <= rdNext;
         wrPtr <= wrNext;
         count <= countNext;
      end
   end

   always_ff @(posedge clock) begin
      if (pushNew) begin
         keyMem[wrPtr]  <= inKey;
         dataMem[wrPtr] <= inData;
         maskMem[wrPtr] <= inMask;
         lastMem[wrPtr] <= inLast;
      end else if (mergeHit) begin
         for (int b = 0; b < MASK_WIDTH; b++) begin
            if (inMask[b]) dataMem[tailPtr][8*b +: 8] <= inData[8*b +: 8];
         end
         maskMem[tailPtr] <= maskMem[tailPtr] | inMask;
         lastMem[tailPtr] <= lastMem[tailPtr] | inLast;
      end
   end

   assign outKey  = keyMem[rdPtr];
   assign outData = dataMem[rdPtr];
   assign outMask = maskMem[rdPtr];
   assign outLast = lastMem[rdPtr];

   // Post-update view of every slot, so status derived from it lines up with count.
   always_comb begin
      rel           = '0;
      slotValidNext = '0;
      slotTagNext   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         rel              = PTR_WIDTH'(i) - rdNext;
         slotValidNext[i] = ({1'b0, rel} < countNext);
         slotTagNext[i*TAG_WIDTH +: TAG_WIDTH] = (pushNew && wrPtr == PTR_WIDTH'(i)) ?
            inKey[TAG_WIDTH-1:0] : keyMem[i][TAG_WIDTH-1:0];
      end
   end

endmodule

// File: rtl/lane_vrf_write_stage.sv
// rtl/lane_vrf_write_stage.sv - lane write-back queue: group-to-VRF address translation and hazard status
module lane_vrf_write_stage
   import lane_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int DEPTH        = 4,
   parameter int GROUP_WIDTH  = 12,
   parameter int OFFSET_WIDTH = VRF_OFFSET_WIDTH,
   parameter int VD_WIDTH     = 5,
   parameter int INDEX_WIDTH  = 3,
   parameter int MERGE_EN     = 1
) (
   input  logic                         clock,
   input  logic                         reset,
   output logic                         enqueue_ready,
   input  logic                         enqueue_valid,
   input  logic [GROUP_WIDTH-1:0]       enqueue_groupCounter,
   input  logic [DATA_WIDTH-1:0]        enqueue_data,
   input  logic [DATA_WIDTH/8-1:0]      enqueue_mask,
   input  logic [VD_WIDTH-1:0]          enqueue_vd,
   input  logic [INDEX_WIDTH-1:0]       enqueue_instructionIndex,
   input  logic                         enqueue_last,
   input  logic                         vrfWriteRequest_ready,
   output logic                         vrfWriteRequest_valid,
   output logic [VD_WIDTH-1:0]          vrfWriteRequest_vd,
   output logic [OFFSET_WIDTH-1:0]      vrfWriteRequest_offset,
   output logic [DATA_WIDTH/8-1:0]      vrfWriteRequest_mask,
   output logic [DATA_WIDTH-1:0]        vrfWriteRequest_data,
   output logic                         vrfWriteRequest_last,
   output logic [INDEX_WIDTH-1:0]       vrfWriteRequest_instructionIndex,
   output logic [$clog2(DEPTH):0]       occupancy,
   output logic [2**INDEX_WIDTH-1:0]    inFlight
);

   localparam int KEY_WIDTH  = VD_WIDTH + OFFSET_WIDTH + INDEX_WIDTH;
   localparam int HIGH_WIDTH = GROUP_WIDTH - OFFSET_WIDTH;
   localparam int SUM_WIDTH  = (VD_WIDTH > HIGH_WIDTH) ? VD_WIDTH : HIGH_WIDTH;

   logic [HIGH_WIDTH-1:0]        groupHigh;
   logic [SUM_WIDTH-1:0]         vdSum;
   logic [KEY_WIDTH-1:0]         inKey, outKey;
   logic [DEPTH-1:0]             slotValidNext;
   logic [DEPTH*INDEX_WIDTH-1:0] slotTagNext;
   logic [2**INDEX_WIDTH-1:0]    inFlightNext;

   // Upper group bits step the register index; the sum wraps within VD_WIDTH.
   assign groupHigh = enqueue_groupCounter[GROUP_WIDTH-1:OFFSET_WIDTH];
   assign vdSum     = SUM_WIDTH'(enqueue_vd) + SUM_WIDTH'(groupHigh);
   assign inKey     = {vdSum[VD_WIDTH-1:0], enqueue_groupCounter[OFFSET_WIDTH-1:0],
                       enqueue_instructionIndex};

   lane_merge_queue #(
      .KEY_WIDTH  (KEY_WIDTH),
      .TAG_WIDTH  (INDEX_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .MERGE_EN   (MERGE_EN)
   ) queue (
      .clock         (clock),
      .reset         (reset),
      .inReady       (enqueue_ready),
      .inValid       (enqueue_valid),
      .inKey         (inKey),
      .inData        (enqueue_data),
      .inMask        (enqueue_mask),
      .inLast        (enqueue_last),
      .outReady      (vrfWriteRequest_ready),
      .outValid      (vrfWriteRequest_valid),
      .outKey        (outKey),
      .outData       (vrfWriteRequest_data),
      .outMask       (vrfWriteRequest_mask),
      .outLast       (vrfWriteRequest_last),
      .count         (occupancy),
      .slotValidNext (slotValidNext),
      .slotTagNext   (slotTagNext)
   );

   assign {vrfWriteRequest_vd, vrfWriteRequest_offset, vrfWriteRequest_instructionIndex} = outKey;

   always_comb begin
      inFlightNext = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (slotValidNext[i]) inFlightNext[slotTagNext[i*INDEX_WIDTH +: INDEX_WIDTH]] = 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) inFlight <= '0;
      else        inFlight <= inFlightNext;
   end

endmodule
